// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter giving four requesters turns on one
// shared 32-bit resource. It drives the mux4_32 select, runs a valid/ready
// handshake with the resource, and aborts transactions via a watchdog.
module rr_bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic       mem_ready_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       mem_valid_o,
  output logic [3:0] ack_o,
  output logic       timeout_err_o,
  output logic       busy_o
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             mem_valid_q, mem_valid_d;
  logic [3:0]       ack_q, ack_d;
  logic             timeout_err_q, timeout_err_d;

  logic [3:0] eligible;
  logic [1:0] candIdx;
  logic [1:0] winIdx;
  logic       winFound;

  // Pick the first eligible requester starting at ptr; the one being acked
  // right now is masked so its still-high registered request is not re-served.
  always_comb begin
    eligible = req_i & ~ack_q;
    candIdx  = '0;
    winIdx   = ptr_q;
    winFound = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      candIdx = ptr_q + 2'(i);
      if (eligible[candIdx]) begin
        winIdx   = candIdx;
        winFound = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for ready or watchdog in BUSY.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    mem_valid_d   = mem_valid_q;
    ack_d         = 4'b0000;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (winFound) begin
          gnt_d       = 4'b0001 << winIdx;
          sel_d       = winIdx;
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          ack_d       = 4'b0001 << sel_q;
          gnt_d       = 4'b0000;
          mem_valid_d = 1'b0;
          ptr_d       = sel_q + 2'd1;
          state_d     = IDLE;
        end else if (cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          gnt_d         = 4'b0000;
          mem_valid_d   = 1'b0;
          ptr_d         = sel_q + 2'd1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      cnt_q         <= '0;
      gnt_q         <= 4'b0000;
      sel_q         <= 2'd0;
      mem_valid_q   <= 1'b0;
      ack_q         <= 4'b0000;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      sel_q         <= sel_d;
      mem_valid_q   <= mem_valid_d;
      ack_q         <= ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign sel_o         = sel_q;
  assign mem_valid_o   = mem_valid_q;
  assign busy_o        = mem_valid_q;
  assign ack_o         = ack_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter built with a short watchdog (TIMEOUT=4).
module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       memReady;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       memValid;
  logic [3:0] ack;
  logic       timeoutErr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rr_bus_arbiter #(
    .TIMEOUT(4),
    .CNT_W  (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .mem_ready_i  (memReady),
    .gnt_o        (gnt),
    .sel_o        (sel),
    .mem_valid_o  (memValid),
    .ack_o        (ack),
    .timeout_err_o(timeoutErr),
    .busy_o       (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for one cycle, then land 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req      = r;
    memReady = rdy;
    @(posedge clk);
    #1;
  endtask

  // Compare every output at once against hand-computed values; busy must track mem_valid.
  task automatic checkOutput(input string tag, input logic [3:0] eGnt, input logic [1:0] eSel,
                             input logic eValid, input logic [3:0] eAck, input logic eTo);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {gnt, sel, memValid, busy, ack, timeoutErr};
    exp = {eGnt, eSel, eValid, eValid, eAck, eTo};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed gnt/sel/valid/busy/ack/to=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    memReady = 1'b0;
    #2;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, mem_ready in the 3rd BUSY cycle
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_grant", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_busy2", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_busy3", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_ack", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    // ptr is now 1, so requester 1 beats requester 0
    applyStimulus(4'b0011, 1'b0);
    checkOutput("ptr_after_single", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("ptr_after_single_ack", 4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0);

    // Reset pulse between edges to bring ptr back to 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // All four requesting, mem_ready tied high: order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("rr_grant%0d", i), 4'b0001 << (i % 4), 2'(i % 4), 1'b1, 4'b0000, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("rr_ack%0d", i), 4'b0000, 2'(i % 4), 1'b0, 4'b0001 << (i % 4), 1'b0);
    end
    // ptr = 1; mem_ready in IDLE is ignored
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rr_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Ack-cycle exclusion with a registered request drop
    applyStimulus(4'b0001, 1'b0);
    checkOutput("excl_grant0", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("excl_ack0", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("excl_grant1", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("excl_ack1", 4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("excl_single", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("excl_idle", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);

    // Timeout: ptr = 2, requester 2 never completed
    applyStimulus(4'b0100, 1'b0);
    checkOutput("to_grant", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("to_busy%0d", i), 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    end
    applyStimulus(4'b0100, 1'b0);
    checkOutput("to_abort", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1);
    // ptr must be 3 after the abort: requester 3 wins over 0 and 2
    applyStimulus(4'b1101, 1'b0);
    checkOutput("to_ptr3", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1101, 1'b1);
    checkOutput("to_ptr3_ack", 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_idle", 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0);

    // mem_ready in the last allowed BUSY cycle wins over the watchdog
    applyStimulus(4'b0100, 1'b0);
    checkOutput("edge_grant", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 1'b0);
    end
    checkOutput("edge_busy4", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("edge_ack", 4'b0000, 2'd2, 1'b0, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("edge_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);

    // Mid-transaction request changes are ignored (ptr = 3)
    applyStimulus(4'b0100, 1'b0);
    checkOutput("dist_grant", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("dist_hold1", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("dist_hold2", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("dist_ack", 4'b0000, 2'd2, 1'b0, 4'b0100, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("dist_next3", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);

    // Reset during BUSY clears outputs immediately; ptr returns to 0
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("rst_held", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 1'b0);
    checkOutput("rst_ptr0", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("rst_ptr0_ack", 4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter sharing one 32-bit datapath resource, such as the data-memory port, among four requesters. It drives the 2-bit select of the downstream mux4_32 that steers requester address and data onto the shared port. It sequences each transaction with a valid/ready handshake to the resource and returns a one-cycle acknowledge to the winner. A watchdog aborts transactions the resource never completes.

## Interface
- TIMEOUT, 15: maximum BUSY cycles per transaction before abort; legal range 1..(2^CNT_W − 1).
- CNT_W, 4: width of the watchdog counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
- req  input  4  level request, one bit per requester; held until `ack` or abort.
- mem_ready  input  1  resource completion, sampled only while `mem_valid`=1.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  mux select, the index of the granted requester; holds the last value while idle.
- mem_valid  output  1  transaction in flight to the resource.
- ack  output  4  one-hot, one-cycle completion pulse to the served requester.
- timeout_err  output  1  one-cycle pulse when a transaction is aborted.
- busy  output  1  equals `mem_valid`.

## Operation
- Two-state FSM: IDLE and BUSY. Internal 2-bit round-robin pointer `ptr` and a CNT_W-bit counter `cnt`.
- Reset, asynchronous: state=IDLE, ptr=0, cnt=0, gnt=0, sel=0, mem_valid=0, busy=0, ack=0, timeout_err=0.
- IDLE, arbitration:
  - Eligible set = req & ~ack. A requester being acknowledged this cycle is excluded, so a registered req that is still high is not re-served.
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible index wins.
  - On a winner, at the clock edge: gnt=onehot(winner), sel=winner, mem_valid=1, cnt=0, state=BUSY.
  - With no eligible requester, remain in IDLE; all outputs hold, except ack and timeout_err, which fall to 0.
- BUSY:
  - gnt, sel and mem_valid are stable for the whole transaction.
  - Dropping `req` mid-transaction has no effect; the transaction always runs to completion or timeout.
  - Request changes by other requesters are ignored.
- BUSY, mem_ready=1:
  - At the edge: ack=onehot(sel) for exactly one cycle, gnt=0, mem_valid=0, ptr=sel+1 (mod 4), state=IDLE.
- BUSY, mem_ready=0 and cnt==TIMEOUT−1:
  - Abort at the edge: timeout_err=1 for one cycle, ack stays 0, gnt=0, mem_valid=0, ptr=sel+1, state=IDLE.
- BUSY, otherwise: cnt increments by 1.
- mem_ready has priority over the timeout in the same cycle: that transaction completes normally.
- mem_ready is ignored in IDLE.
- Invariants: gnt is zero or one-hot; ack and timeout_err are never both high; ack is never high in two consecutive cycles.

## Timing
- Grant latency: req sampled high at edge E in IDLE → gnt, sel and mem_valid valid in the cycle after E.
- Transaction length: mem_ready high in the k-th BUSY cycle (k ≥ 1) → ack in cycle k+1 after the grant edge, and gnt=0 in that same cycle.
- Minimum transaction is 1 BUSY cycle plus 1 IDLE cycle. Back-to-back grants to different requesters are therefore spaced 2 cycles apart; the IDLE cycle coincides with the ack pulse.
- Abort occurs after exactly TIMEOUT BUSY cycles without mem_ready; timeout_err is asserted in the following cycle.
- Reset asserted mid-transaction: all outputs clear asynchronously with no ack and no timeout_err; ptr=0 after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single request, reset release:
  - Stimulus: req=0001; mem_ready pulsed in the 3rd BUSY cycle.
  - Required: gnt=0001, sel=0, mem_valid=1 one cycle after req; ack=0001 for one cycle; next ptr=1.
- All four requesting continuously, mem_ready tied high:
  - Required: grant order 0,1,2,3,0; each grant lasts 1 cycle, separated by 1 IDLE cycle; no requester is served twice in a row while others wait.
- Ack-cycle exclusion:
  - Stimulus: req=0011 with a registered drop (req[0] falls one cycle after its ack).
  - Required: second grant goes to requester 1, not 0.
- Timeout, TIMEOUT=4:
  - Stimulus: req=0100, mem_ready=0.
  - Required: mem_valid high for exactly 4 cycles, then timeout_err=1 for one cycle, ack=0, ptr=3.
  - Repeat with mem_ready=1 in the 4th BUSY cycle → ack=0100 and timeout_err=0.
- Mid-transaction disturbances:
  - Stimulus: during BUSY for requester 2, drop req[2] and raise req[3].
  - Required: gnt stays 0100 until mem_ready; then requester 3 is granted.
  - Stimulus: assert rst_n=0 during BUSY.
  - Required: gnt, mem_valid and ack go to 0 immediately; after release the first grant honours ptr=0.
